// File: rtl/network_mul_share_arb.sv
// Round-robin share of one pipelined 15s x 16s multiplier among NUM_REQ requesters.
// Requester IDs ride a {vld,id} pipe that freezes with the multiplier on stall.
module network_mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*15-1:0] req_a,
    input  logic [NUM_REQ*16-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  mul_ce,
    output logic [14:0]           mul_din0,
    output logic [15:0]           mul_din1,
    input  logic [29:0]           mul_dout,
    output logic                  res_valid,
    output logic [ID_W-1:0]       res_id,
    output logic [29:0]           res_data,
    input  logic                  res_ready,
    output logic                  busy
);

    logic [ID_W-1:0]    r_rr;
    logic [MUL_LAT-1:0] r_vld;
    logic [ID_W-1:0]    r_id [MUL_LAT];

    logic               w_issue;
    logic [ID_W-1:0]    w_gid;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx [NUM_REQ];

    assign mul_ce = ~reset & ~(res_valid & ~res_ready);

    // Candidate order: rr, rr+1, ... wrapping modulo NUM_REQ
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_idx
        assign w_idx[k] = ID_W'((32'(r_rr) + k) % NUM_REQ);
    end

    always_comb begin
        w_issue = 1'b0;
        w_gid   = '0;
        w_grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (mul_ce && !w_issue && req_valid[w_idx[k]]) begin
                w_issue = 1'b1;
                w_gid   = w_idx[k];
            end
        end
        if (w_issue) begin
            w_grant[w_gid] = 1'b1;
        end
    end

    assign req_ready = w_grant;
    assign mul_din0  = w_issue ? req_a[int'(w_gid)*15 +: 15] : '0;
    assign mul_din1  = w_issue ? req_b[int'(w_gid)*16 +: 16] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr  <= '0;
            r_vld <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                r_id[i] <= '0;
            end
        end else if (mul_ce) begin
            r_vld[0] <= w_issue;
            r_id[0]  <= w_gid;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_id[i]  <= r_id[i-1];
            end
            if (w_issue) begin
                r_rr <= (w_gid == ID_W'(NUM_REQ - 1)) ? '0 : w_gid + 1'b1;
            end
        end
    end

    assign res_valid = r_vld[MUL_LAT-1];
    assign res_id    = r_id[MUL_LAT-1];
    assign res_data  = mul_dout;
    assign busy      = |r_vld;

endmodule
